// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's decode/control stage and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one result bit per cycle on unsigned
// magnitudes, with sign correction applied in a single fix-up cycle.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q;
  logic [2:0]        funct3_q;
  logic              sa_q;
  logic              sb_q;
  logic [XLEN-1:0]   bop_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNTW-1:0]   count_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [XLEN-1:0]   result_q;

  logic              signed_a;
  logic              signed_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              b_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.result    = result_q;

  // Which operands are interpreted as two's complement for the incoming op.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (io.funct3)
      3'd1, 3'd4, 3'd6: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'd2:    signed_a = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = signed_a & io.op_a[XLEN-1];
  assign b_neg = signed_b & io.op_b[XLEN-1];
  assign a_mag = a_neg ? -io.op_a : io.op_a;
  assign b_mag = b_neg ? -io.op_b : io.op_b;

  // Divide by zero and signed overflow bypass the iteration entirely.
  assign b_zero  = (io.op_b == '0);
  assign div_ovf = (io.op_a == MIN_NEG) && (io.op_b == '1);
  assign special = io.funct3[2] && (b_zero || (div_ovf && !io.funct3[0]));

  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = io.funct3[1] ? io.op_a : '1;
    end else begin
      special_res = io.funct3[1] ? '0 : io.op_a;
    end
  end

  // Shift-add: acc = {partial product high, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bop_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, bop_q};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      3'd0:             fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = quo_fix;
      default:          fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      bop_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!io.flush && io.in_valid) begin
            funct3_q   <= io.funct3;
            sa_q       <= a_neg;
            sb_q       <= b_neg;
            // Multiplicand or divisor stays put; the other operand is shifted.
            bop_q      <= io.funct3[2] ? b_mag : a_mag;
            acc_q      <= {{XLEN{1'b0}}, (io.funct3[2] ? a_mag : b_mag)};
            count_q    <= CNTW'(XLEN);
            in_ready_q <= 1'b0;
            if (special) begin
              state_q     <= S_DONE;
              result_q    <= special_res;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (io.flush) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            acc_q   <= funct3_q[2] ? div_next : mul_next;
            count_q <= count_q - 1'b1;
            if (count_q == CNTW'(1)) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (io.flush) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end else begin
            state_q     <= S_DONE;
            result_q    <= fix_res;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          // A flush together with out_ready still abandons the result.
          if (io.flush || io.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV64M vectors, special cases,
// backpressure, flush and mid-operation reset.
module tb_muldiv_unit;

  localparam int XLEN  = 64;
  localparam int LAT_N = XLEN + 1;
  localparam int LAT_S = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  logic clk;
  logic rst;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int total  = 0;
  int passed = 0;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge after valid&ready is seen here.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_result got=%h expected=none", bus.result);
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e);
          $display("result %h expected %h", bus.result, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one request; returns 1 time unit after the accept edge with the
  // operand buses scrambled so late changes would corrupt a sloppy sampler.
  task automatic start(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.funct3   = f;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = b ^ 64'h5;
    bus.funct3   = f ^ 3'b001;
  endtask

  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    int k = 0;
    exp_q.push_back(exp);
    start(f, a, b);
    while (!bus.out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 64'(k), 64'(lat));
  endtask

  task automatic drain();
    int n = 0;
    while (bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, bus.busy},      64'd0);
    chk("rst_result",    bus.result,             64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("idle_result",    bus.result,             64'd0);

    // Multiplies
    issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, LAT_N); drain();
    issue(3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, LAT_N); drain();
    issue(3'd1, ONES, ONES, 64'd0, LAT_N); drain();
    issue(3'd2, ONES, ONES, ONES, LAT_N); drain();
    issue(3'd1, 64'h4000_0000_0000_0000, 64'd4, 64'd1, LAT_N); drain();

    // Divides
    issue(3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, LAT_N); drain();
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, LAT_N); drain();
    issue(3'd5, 64'd20, 64'd6, 64'd3, LAT_N); drain();
    issue(3'd4, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, LAT_N); drain();
    issue(3'd7, 64'd20, 64'd6, 64'd2, LAT_N); drain();
    issue(3'd5, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, LAT_N); drain();
    issue(3'd5, MINN, ONES, 64'd0, LAT_N); drain();

    // Divide by zero and signed overflow
    issue(3'd5, 64'd5, 64'd0, ONES, LAT_S); drain();
    issue(3'd6, 64'd5, 64'd0, 64'd5, LAT_S); drain();
    issue(3'd4, MINN, ONES, MINN, LAT_S); drain();
    issue(3'd6, MINN, ONES, 64'd0, LAT_S); drain();

    // flush beats in_valid in IDLE
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.funct3   = 3'd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("idle_flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("idle_flush_busy",     {63'd0, bus.busy},     64'd0);

    // Backpressure: result held, new requests ignored
    bus.out_ready = 1'b0;
    issue(3'd5, 64'd100, 64'd7, 64'd14, LAT_N);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.funct3   = 3'd0;
        bus.op_a     = 64'd9;
        bus.op_b     = 64'd9;
      end else if (i == 5) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_result",   bus.result,              64'd14);
      chk("bp_in_ready", {63'd0, bus.in_ready},   64'd0);
      chk("bp_valid",    {63'd0, bus.out_valid},  64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid",    {63'd0, bus.out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'd0, bus.in_ready},  64'd1);

    // Flush mid-divide
    start(3'd4, 64'd1000, 64'd3);
    repeat (29) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", {63'd0, bus.in_ready},  64'd1);
    chk("flush_busy",     {63'd0, bus.busy},      64'd0);
    chk("flush_valid",    {63'd0, bus.out_valid}, 64'd0);
    chk("flush_result",   bus.result,             64'd14);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // Reset mid-multiply
    start(3'd0, 64'd123456, 64'd654321);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", {63'd0, bus.in_ready},  64'd1);
    chk("mrst_busy",     {63'd0, bus.busy},      64'd0);
    chk("mrst_valid",    {63'd0, bus.out_valid}, 64'd0);
    chk("mrst_result",   bus.result,             64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(3'd0, 64'd3, 64'd4, 64'd12, LAT_N); drain();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution unit for the next-generation core.
- Sits beside the ALU and is started by the decode/control stage for OP instructions with funct7=0000001.
- Computes one result bit per cycle, parametrised in XLEN, with valid/ready handshakes on both sides so the core stalls while the unit is busy.

Parameters:
XLEN, 64, operand/result width in bits (32 or 64).
CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept request (high only in IDLE)
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a  input  XLEN  rs1 operand
op_b  input  XLEN  rs2 operand
flush  input  1  abort current operation
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  XLEN  result, stable while out_valid=1
busy  output  1  high in CALC or FIX

Behaviour:
- Reset (rst=0, asynchronous) forces IDLE. Outputs: in_ready=1, out_valid=0, busy=0, result=0. All internal registers clear.
- States:
  - IDLE: in_ready=1. On in_valid: latch funct3 and operand signs, and load magnitudes. Signed: op_a for 1,2,4,6; op_b for 1,4,6. Set count=XLEN, then go to CALC.
  - Special cases go from IDLE straight to DONE on the accept edge:
    - DIV/DIVU with op_b=0: quotient = all ones.
    - REM/REMU with op_b=0: result = op_a.
    - DIV with op_a=100..0 and op_b=all ones: result = op_a.
    - REM in the same overflow case: result = 0.
  - CALC: one step per cycle, count decrements; count reaching 0 moves to FIX.
    - Multiply step: shift-add over a 2*XLEN accumulator.
    - Divide step: restoring, one quotient bit per cycle.
  - FIX: apply sign correction, select output, register result, then go to DONE.
    - Product is negated (2*XLEN two's complement) if the sign flags differ.
    - Quotient sign = sa^sb. Remainder sign = sa.
    - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - DONE: out_valid=1 and result held. On out_ready, go to IDLE, with out_valid low the next cycle. No new request is accepted in DONE.
- Latency:
  - Normal path: accept edge E0; out_valid is high after edge E(XLEN+1), i.e. XLEN+1 cycles. With XLEN=64, that is 65 cycles.
  - Special-case path: out_valid is high after E0, i.e. 1 cycle.
- Handshake:
  - in_valid is ignored while in_ready=0.
  - Operands are sampled only on the accept edge; later changes to op_a/op_b/funct3 have no effect.
- flush:
  - In CALC, FIX or DONE: return to IDLE on the next edge, with out_valid=0 and result unchanged.
  - In IDLE: flush has priority over in_valid, and no request is accepted.
- Simultaneous events:
  - out_ready in a cycle without out_valid is ignored.
  - flush and out_ready together in DONE: go to IDLE, and the result counts as not consumed.
- Arithmetic: all operand-width arithmetic is exact modulo 2^XLEN; there are no exceptions or traps.
- Reset asserted mid-operation: unit returns to the IDLE/reset values immediately. After release, the first accepted request behaves normally.

Test Plan:
- Reset check: hold rst=0 for 3 cycles -> in_ready=1, out_valid=0, busy=0, result=0. Release, idle 5 cycles -> no change.
- MUL: op_a=7, op_b=-3 (0xFFFF...FFFD), funct3=0 -> out_valid after 65 cycles, result=0xFFFFFFFFFFFFFFEB (-21). With funct3=3 (MULHU), op_a=op_b=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE.
- DIV/REM signed: op_a=-20, op_b=6 -> DIV result -3, REM result -2. DIVU with op_a=20, op_b=6 -> result 3.
- Divide by zero and overflow:
  - DIVU 5/0 -> result 0xFFFFFFFFFFFFFFFF, out_valid one cycle after accept.
  - REM 5/0 -> result 5.
  - DIV 0x8000000000000000/-1 -> result 0x8000000000000000; REM on the same operands -> result 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0. Pulse in_valid during that time -> ignored. Raise out_ready -> IDLE next cycle.
- Abort: flush at cycle 30 of a DIV -> IDLE next edge, with no out_valid. Separately, pull rst low at cycle 20 of a MUL -> immediate reset values, and a following MUL 3*4 returns 12.
